// File: rtl/positaccum_to_posit16_es2_pkg.sv
// Shared definitions for the posit16 es=2 encoder: serialized accumulator
// layout, posit16 special encodings and the field-unpack helper.
package positaccum_to_posit16_es2_pkg;

  localparam int FBITS_ACCUM = 24;
  // {sgn, scale[7:0], fraction[FB-1:0], inf, zero}
  localparam int POSIT_SERIALIZED_WIDTH_ACCUM_ES2 = 1 + 8 + FBITS_ACCUM + 2;

  localparam logic [15:0] POSIT16_ES2_MAXPOS = 16'h7FFF;
  localparam logic [15:0] POSIT16_ES2_MINPOS = 16'h0001;
  localparam logic [15:0] POSIT16_ES2_NAR    = 16'h8000;
  localparam int          SCALE_MAX_P16E2    = 56;

  typedef struct packed {
    logic                   sgn;
    logic [7:0]             scale;
    logic [FBITS_ACCUM-1:0] frac;
    logic                   inf;
    logic                   zero;
  } accum_t;

  // Split a serialized accumulator word into its fields.
  function automatic accum_t unpack_accum(input logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES2-1:0] d);
    return accum_t'(d);
  endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even on a posit body, clamped to [minpos, maxpos] so a
// finite value never rounds to zero or wraps into NaR.
module posit_round_rne #(
  parameter int W = 15
) (
  input  logic [W-1:0] body,
  input  logic         guard,
  input  logic         sticky,
  output logic [W-1:0] rounded
);

  logic         rnd_up;
  logic [W:0]   sum;

  assign rnd_up = guard & (sticky | body[0]);
  assign sum    = {1'b0, body} + {{W{1'b0}}, rnd_up};

  // Carry out of the body means past maxpos; an all-zero body means below minpos.
  always_comb begin
    rounded = sum[W-1:0];
    if (sum[W])
      rounded = {W{1'b1}};
    else if (sum[W-1:0] == '0)
      rounded = {{(W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/positaccum_to_posit16_es2.sv
// Encodes a serialized ES2 accumulator value into a 16-bit es=2 posit.
// Three register stages (classify, regime shift, round/sign) sharing one
// enable driven by the output handshake.
module positaccum_to_posit16_es2
  import positaccum_to_posit16_es2_pkg::*;
#(
  parameter int N  = 16,
  parameter int ES = 2,
  parameter int FB = FBITS_ACCUM
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_ES2-1:0] in_data,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  output logic [N-1:0]                                out_posit,
  output logic                                        out_valid,
  input  logic                                        out_ready
);

  localparam int STAGES = 3;
  // {regime lead, regime stop, e, f} followed by room for a full-body shift
  localparam int SW = 2 + ES + FB + (N - 1);
  localparam logic signed [7:0] SCALE_HI = $signed(8'(SCALE_MAX_P16E2));
  localparam logic signed [7:0] SCALE_LO = -SCALE_HI;

  logic            en;
  logic [STAGES:1] vld_pipe;
  accum_t          in_f;

  // stage 1
  logic          s1_sgn, s1_rs, s1_sat_hi, s1_sat_lo, s1_inf, s1_zero;
  logic [3:0]    s1_shamt;
  logic [ES-1:0] s1_e;
  logic [FB-1:0] s1_frac;

  // stage 2
  logic          s2_sgn, s2_guard, s2_sticky, s2_sat_hi, s2_sat_lo, s2_inf, s2_zero;
  logic [N-2:0]  s2_body;

  logic signed [SW-1:0] sh_str;
  logic [N-2:0]         rounded, mag;
  logic [N-1:0]         posit_nxt;

  assign out_valid = vld_pipe[STAGES];
  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign in_f      = unpack_accum(in_data);

  // Regime string: k>=0 gives k+1 ones then a zero, k<0 gives -k zeros then a
  // one. Arithmetic-shifting {rs, ~rs, e, f} by k (or ~k when negative) builds
  // it directly; k = scale >>> 2, so k's low bits are scale[5:2].
  assign sh_str = $signed({s1_rs, ~s1_rs, s1_e, s1_frac, {(N-1){1'b0}}}) >>> s1_shamt;

  posit_round_rne #(.W(N-1)) u_rnd (
    .body    (s2_body),
    .guard   (s2_guard),
    .sticky  (s2_sticky),
    .rounded (rounded)
  );

  // Saturation overrides rounding; specials override everything, sign ignored.
  always_comb begin
    mag = rounded;
    if (s2_sat_hi)      mag = POSIT16_ES2_MAXPOS[N-2:0];
    else if (s2_sat_lo) mag = POSIT16_ES2_MINPOS[N-2:0];
    posit_nxt = s2_sgn ? -{1'b0, mag} : {1'b0, mag};
    if (s2_inf)       posit_nxt = POSIT16_ES2_NAR;
    else if (s2_zero) posit_nxt = '0;
  end

  // Valid shift register; bubbles advance with the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // Stage 1: latch fields, classify saturation, precompute regime shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {s1_sgn, s1_rs, s1_sat_hi, s1_sat_lo, s1_inf, s1_zero} <= '0;
      s1_shamt <= '0;
      s1_e     <= '0;
      s1_frac  <= '0;
    end else if (en && in_valid) begin
      s1_sgn    <= in_f.sgn;
      s1_rs     <= ~in_f.scale[7];
      s1_shamt  <= in_f.scale[7] ? ~in_f.scale[5:2] : in_f.scale[5:2];
      s1_e      <= in_f.scale[ES-1:0];
      s1_frac   <= in_f.frac;
      s1_sat_hi <= $signed(in_f.scale) > SCALE_HI;
      s1_sat_lo <= $signed(in_f.scale) < SCALE_LO;
      s1_inf    <= in_f.inf;
      s1_zero   <= in_f.zero;
    end
  end

  // Stage 2: top N-1 bits are the body, next is guard, the rest fold to sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {s2_sgn, s2_guard, s2_sticky, s2_sat_hi, s2_sat_lo, s2_inf, s2_zero} <= '0;
      s2_body <= '0;
    end else if (en && vld_pipe[1]) begin
      s2_sgn    <= s1_sgn;
      s2_body   <= sh_str[SW-1 -: N-1];
      s2_guard  <= sh_str[SW-N];
      s2_sticky <= |sh_str[SW-N-1:0];
      s2_sat_hi <= s1_sat_hi;
      s2_sat_lo <= s1_sat_lo;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
    end
  end

  // Stage 3: registered encoded posit; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    out_posit <= '0;
    else if (en && vld_pipe[2])  out_posit <= posit_nxt;
  end

endmodule

// File: doc/positaccum_to_posit16_es2.md
Name: positaccum_to_posit16_es2

Overview:
- Downstream stage of the ES2 raw posit accumulator.
- Takes the serialized accumulator value and encodes it into a standard 16-bit, es=2 posit word.
  - Serialized value fields: sgn, 8-bit scale, FBITS_ACCUM-bit fraction, inf, zero.
  - Encoding includes regime generation, round-to-nearest-even and saturation.
- 3-stage pipeline with a valid/ready handshake, so results can be streamed to memory or a host interface.

Parameters:
- N, 16, output posit width (fixed for this instance; used for regime bounds)
- ES, 2, exponent field width
- FB, FBITS_ACCUM, input fraction width, taken from posit_defines

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- in_data  in  POSIT_SERIALIZED_WIDTH_ACCUM_ES2  accumulator result
  - Bit layout, MSB to LSB: {sgn, scale[7:0], fraction[FB-1:0], inf, zero}
- in_valid  in  1  in_data is valid
- in_ready  out  1  stage can accept in_data this cycle
- out_posit  out  16  encoded posit
- out_valid  out  1  out_posit is valid
- out_ready  in  1  consumer accepts out_posit

Behaviour:
- Reset (rst=0, asynchronous):
  - All stage valid bits clear; out_valid=0, out_posit=16'h0000.
  - in_ready follows its equation and reads 1 while in reset.
  - Reset mid-stream drops all in-flight items; nothing is emitted after release until new input arrives.
- Handshake:
  - Pipeline enable en = ~out_valid | out_ready; in_ready = en.
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - When en=0, all three stages hold data and valid bits unchanged.
  - Bubbles are not compressed.
  - out_posit must stay stable while out_valid=1 and out_ready=0.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput: 1 result per cycle.
- Stage 1 (register and classify):
  - Latch the fields.
  - k = scale >>> 2 (arithmetic); e = scale[1:0].
  - sat_hi = scale > 56; sat_lo = scale < -56.
  - special = inf | zero.
- Stage 2 (build body):
  - Form the 15-bit-plus-tail string R|E|F.
    - k>=0: R is k+1 ones followed by a zero.
    - k<0: R is -k zeros followed by a one.
  - Take the top 15 bits as the body.
  - guard = next bit after the body.
  - sticky = OR of all remaining bits, including truncated regime, exponent and fraction bits.
  - Implemented as a right shift of {R_prefix, e, fraction} by the regime length.
- Stage 3 (round, sign, special):
  - Round up if guard & (sticky | body[0]).
  - If the rounded body overflows past 15'h7FFF, clamp to 15'h7FFF.
  - A rounded body of 0 becomes 15'h0001; posits never round to zero.
  - sat_hi forces body=7FFF; sat_lo forces body=0001.
  - Negative sign: out = two's complement of {1'b0, body}.
  - inf → 16'h8000 (NaR). inf has priority over zero; zero → 16'h0000.
  - The sgn field is ignored for special values.
- Width rules:
  - scale is signed 8-bit; k fits in signed 7-bit.
  - Regime length is at most 15 and the shifter is sized for it.
  - The fraction MSB carries weight 2^-1; the hidden bit is implicit.
- No internal state beyond the pipeline registers.
- inf/zero simultaneously with sat flags: the special value wins.

Decomposition:
- Add to posit_defines:
  - POSIT16_ES2_MAXPOS=16'h7FFF, MINPOS=16'h0001, NAR=16'h8000
  - SCALE_MAX_P16E2=56
  - A field-unpack helper function for the serialized accum layout; value_accum is reused.
- One sub-module is natural: posit_round_rne, the stage-3 combinational core.
  - Inputs: body, guard, sticky.
  - Outputs: rounded body, with clamp to [0001, 7FFF].
  - Unit-testable alone.
- Regime shift reuses the existing shift_right module.

Test Plan:
- Basic values, no stall:
  - sgn=0, scale=0, frac=0 → 16'h4000 exactly 3 cycles after the transfer.
  - scale=1 → 16'h4800.
  - sgn=1, scale=0 → 16'hC000.
- Ties and rounding at scale=0:
  - frac with only bit 2^-12 set (tie, even LSB) → 16'h4000.
  - frac with 2^-11 and 2^-12 set (tie, odd LSB) → 16'h4002.
  - frac with 2^-12 and 2^-20 set → 16'h4001.
- Saturation:
  - scale=60 → 16'h7FFF.
  - scale=-60 → 16'h0001.
  - sgn=1, scale=-60 → 16'hFFFF.
  - scale=56 with frac all ones → 16'h7FFF (no wrap to NaR).
- Specials: zero=1 → 16'h0000; inf=1 → 16'h8000; inf=1 and zero=1 → 16'h8000.
- Backpressure:
  - Stream 6 values with out_ready toggling 1,0,0,1,...
  - Required: in_ready==out_ready whenever out_valid=1.
  - out_posit stays stable during stalls.
  - All 6 results arrive in order, none lost or duplicated.
- Asynchronous reset:
  - Assert rst=0 mid-cycle with 3 items in flight.
  - out_valid=0 and out_posit=0 immediately, before the next edge.
  - After release with in_valid=0, no output ever appears.
